// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizes for the hazard scoreboard and its fetch-cancel counter.
package hazard_scoreboard_pkg;

   localparam int NUM_GR_DFLT     = 32;
   localparam int GR_W_DFLT       = $clog2(NUM_GR_DFLT);
   localparam int PIPE_DEPTH_DFLT = 4;
   localparam int MAX_FETCH_DFLT  = 4;

   typedef enum logic [1:0] {
      WK_ALU  = 2'd0,
      WK_LOAD = 2'd1,
      WK_CSR  = 2'd2
   } wr_kind_t;

   typedef logic [GR_W_DFLT-1:0] gr_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/WB/fetch/flush signal bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int GR_W    = 5,
   parameter int OUT_W   = 3
) ();

   logic                    id_valid;
   logic                    id_fire;
   logic [NUM_SRC-1:0]      id_src_valid;
   logic [NUM_SRC*GR_W-1:0] id_src_no;
   logic [NUM_SRC-1:0]      id_src_early;
   logic                    id_wen;
   logic [GR_W-1:0]         id_rd_no;
   wr_kind_t                id_wkind;
   logic                    wb_fire;
   logic                    wb_wen;
   logic [GR_W-1:0]         wb_rd_no;
   logic                    kill_younger;
   logic                    wb_kill;
   logic                    id_redirect;
   logic                    fetch_req_fire;
   logic                    fetch_data_ok;

   logic                    fetch_req_ready;
   logic                    id_stall;
   logic                    ex_bubble;
   logic                    front_flush;
   logic                    wb_flush;
   logic                    fetch_discard;
   logic [OUT_W-1:0]        outstanding;
   logic                    sb_busy;

   modport master (
      output id_valid, id_fire, id_src_valid, id_src_no, id_src_early,
             id_wen, id_rd_no, id_wkind, wb_fire, wb_wen, wb_rd_no,
             kill_younger, wb_kill, id_redirect, fetch_req_fire, fetch_data_ok,
      input  fetch_req_ready, id_stall, ex_bubble, front_flush, wb_flush,
             fetch_discard, outstanding, sb_busy
   );

   modport slave (
      input  id_valid, id_fire, id_src_valid, id_src_no, id_src_early,
             id_wen, id_rd_no, id_wkind, wb_fire, wb_wen, wb_rd_no,
             kill_younger, wb_kill, id_redirect, fetch_req_fire, fetch_data_ok,
      output fetch_req_ready, id_stall, ex_bubble, front_flush, wb_flush,
             fetch_discard, outstanding, sb_busy
   );

endinterface

// File: rtl/hazard_scoreboard_fetch_cancel_ctr.sv
// Outstanding instruction-fetch counter plus a cancel counter that marks returning
// data of redirected-away fetches for discard.
module fetch_cancel_ctr
   import hazard_scoreboard_pkg::*;
#(
   parameter int MAX_FETCH = MAX_FETCH_DFLT,
   parameter int OUT_W     = $clog2(MAX_FETCH + 1)
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             fetch_req_fire,
   input  logic             fetch_data_ok,
   input  logic             cancel_trigger,
   output logic             fetch_req_ready,
   output logic             fetch_discard,
   output logic [OUT_W-1:0] outstanding
);

   logic [OUT_W-1:0] out_q;
   logic [OUT_W-1:0] cancel_q;

   assign outstanding     = out_q;
   assign fetch_req_ready = (out_q < OUT_W'(MAX_FETCH));
   assign fetch_discard   = fetch_data_ok & (cancel_q != '0);

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         out_q    <= '0;
         cancel_q <= '0;
      end else begin
         case ({fetch_req_fire, fetch_data_ok})
            2'b10: if (out_q != OUT_W'(MAX_FETCH)) out_q <= out_q + OUT_W'(1);
            2'b01: if (out_q != '0) out_q <= out_q - OUT_W'(1);
            default: out_q <= out_q;
         endcase

         // A request fired alongside the trigger is the redirected fetch, so it
         // is deliberately left out of the cancel load.
         if (cancel_trigger)
            cancel_q <= out_q - OUT_W'(fetch_data_ok & ~fetch_discard);
         else if (fetch_discard)
            cancel_q <= cancel_q - OUT_W'(1);
      end
   end

   a_no_fire_when_full: assert property (@(posedge aclk) disable iff (reset)
      !(fetch_req_fire && !fetch_req_ready));

   a_no_data_without_req: assert property (@(posedge aclk) disable iff (reset)
      !(fetch_data_ok && out_q == '0));

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-GR in-flight writer scoreboard deciding ID stall/EX bubble, plus flush fan-out
// and fetch-cancel accounting for redirects.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_GR     = NUM_GR_DFLT,
   parameter int GR_W       = $clog2(NUM_GR),
   parameter int NUM_SRC    = 3,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DFLT,
   parameter int MAX_FETCH  = MAX_FETCH_DFLT
) (
   input  logic              aclk,
   input  logic              reset,
   hazard_scoreboard_if.slave bus
);

   localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_FETCH + 1);

   logic [CNT_W-1:0] cnt_q  [NUM_GR];
   wr_kind_t         kind_q [NUM_GR];
   logic [NUM_GR-1:0] inc;
   logic [NUM_GR-1:0] dec;
   logic              sb_clear;
   logic              sb_ovf;
   logic              sb_unf;
   logic              busy;

   logic [GR_W-1:0]    src_no [NUM_SRC];
   logic [NUM_SRC-1:0] hz;
   logic               stall;
   logic               cancel_trigger;

   assign sb_clear = bus.kill_younger | bus.wb_kill;

   // GR 0 is hard-wired, so its counter never moves and stays at zero.
   always_comb begin
      inc    = '0;
      dec    = '0;
      sb_ovf = 1'b0;
      sb_unf = 1'b0;
      busy   = 1'b0;
      for (int r = 1; r < NUM_GR; r++) begin
         inc[r] = bus.id_fire & bus.id_wen & (bus.id_rd_no == GR_W'(r)) & ~bus.kill_younger;
         dec[r] = bus.wb_fire & bus.wb_wen & (bus.wb_rd_no == GR_W'(r)) & ~bus.wb_kill;
      end
      for (int r = 0; r < NUM_GR; r++) begin
         if (!sb_clear && inc[r] && !dec[r] && cnt_q[r] == CNT_W'(PIPE_DEPTH)) sb_ovf = 1'b1;
         if (!sb_clear && dec[r] && !inc[r] && cnt_q[r] == '0) sb_unf = 1'b1;
         if (cnt_q[r] != '0) busy = 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_GR; r++) begin
            cnt_q[r]  <= '0;
            kind_q[r] <= WK_ALU;
         end
      end else begin
         for (int r = 0; r < NUM_GR; r++) begin
            if (sb_clear)
               cnt_q[r] <= '0;
            else if (inc[r] && !dec[r]) begin
               if (cnt_q[r] != CNT_W'(PIPE_DEPTH)) cnt_q[r] <= cnt_q[r] + CNT_W'(1);
            end else if (dec[r] && !inc[r]) begin
               if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - CNT_W'(1);
            end
            if (inc[r]) kind_q[r] <= bus.id_wkind;
         end
      end
   end

   // An ALU producer is forwarded to late consumers; anything else must wait for WB.
   always_comb begin
      hz = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_no[i] = bus.id_src_no[i*GR_W +: GR_W];
         hz[i] = bus.id_valid & bus.id_src_valid[i] & (src_no[i] != '0) &
                 (cnt_q[src_no[i]] != '0) &
                 ((kind_q[src_no[i]] != WK_ALU) | bus.id_src_early[i]);
      end
   end

   assign stall          = (|hz) & ~bus.kill_younger;
   assign bus.id_stall    = stall;
   assign bus.ex_bubble   = stall;
   assign bus.front_flush = bus.kill_younger | bus.wb_kill;
   assign bus.wb_flush    = bus.wb_kill;
   assign bus.sb_busy     = busy;

   assign cancel_trigger = (bus.id_redirect & ~stall) | bus.kill_younger | bus.wb_kill;

   fetch_cancel_ctr #(
      .MAX_FETCH (MAX_FETCH),
      .OUT_W     (OUT_W)
   ) u_fetch_cancel_ctr (
      .aclk            (aclk),
      .reset           (reset),
      .fetch_req_fire  (bus.fetch_req_fire),
      .fetch_data_ok   (bus.fetch_data_ok),
      .cancel_trigger  (cancel_trigger),
      .fetch_req_ready (bus.fetch_req_ready),
      .fetch_discard   (bus.fetch_discard),
      .outstanding     (bus.outstanding)
   );

   a_sb_no_overflow: assert property (@(posedge aclk) disable iff (reset) !sb_ovf);
   a_sb_no_underflow: assert property (@(posedge aclk) disable iff (reset) !sb_unf);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected outputs, a negedge
// monitor pops and compares them.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int GR_W    = 5;
   localparam int NUM_SRC = 3;
   localparam int OUT_W   = 3;

   localparam int S_STALL   = 0;
   localparam int S_BUBBLE  = 1;
   localparam int S_FFLUSH  = 2;
   localparam int S_WBFLUSH = 3;
   localparam int S_DISCARD = 4;
   localparam int S_READY   = 5;
   localparam int S_OUTST   = 6;
   localparam int S_BUSY    = 7;

   typedef struct {
      int sig;
      int exp;
      int step;
   } exp_t;

   logic aclk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step_no = 0;
   exp_t exp_q[$];

   always #5 aclk = ~aclk;

   hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .GR_W(GR_W), .OUT_W(OUT_W)) bus ();

   hazard_scoreboard dut (
      .aclk  (aclk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic int sample(input int sig);
      case (sig)
         S_STALL:   return int'(bus.id_stall);
         S_BUBBLE:  return int'(bus.ex_bubble);
         S_FFLUSH:  return int'(bus.front_flush);
         S_WBFLUSH: return int'(bus.wb_flush);
         S_DISCARD: return int'(bus.fetch_discard);
         S_READY:   return int'(bus.fetch_req_ready);
         S_OUTST:   return int'(bus.outstanding);
         S_BUSY:    return int'(bus.sb_busy);
         default:   return -1;
      endcase
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         S_STALL:   return "id_stall";
         S_BUBBLE:  return "ex_bubble";
         S_FFLUSH:  return "front_flush";
         S_WBFLUSH: return "wb_flush";
         S_DISCARD: return "fetch_discard";
         S_READY:   return "fetch_req_ready";
         S_OUTST:   return "outstanding";
         S_BUSY:    return "sb_busy";
         default:   return "unknown";
      endcase
   endfunction

   always @(negedge aclk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         int   act;
         e   = exp_q.pop_front();
         act = sample(e.sig);
         n_tests++;
         if (act != e.exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", sig_name(e.sig), e.step, act, e.exp);
         end
      end
   end

   task automatic expect_sig(input int sig, input int val);
      exp_t e;
      e.sig  = sig;
      e.exp  = val;
      e.step = step_no;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      bus.id_valid       = 1'b0;
      bus.id_fire        = 1'b0;
      bus.id_src_valid   = '0;
      bus.id_src_no      = '0;
      bus.id_src_early   = '0;
      bus.id_wen         = 1'b0;
      bus.id_rd_no       = '0;
      bus.id_wkind       = WK_ALU;
      bus.wb_fire        = 1'b0;
      bus.wb_wen         = 1'b0;
      bus.wb_rd_no       = '0;
      bus.kill_younger   = 1'b0;
      bus.wb_kill        = 1'b0;
      bus.id_redirect    = 1'b0;
      bus.fetch_req_fire = 1'b0;
      bus.fetch_data_ok  = 1'b0;
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      idle();
      step_no++;
   endtask

   task automatic issue(input int rd, input wr_kind_t k);
      bus.id_fire  = 1'b1;
      bus.id_wen   = 1'b1;
      bus.id_rd_no = GR_W'(rd);
      bus.id_wkind = k;
   endtask

   task automatic rd_src(input int slot, input int r, input bit early);
      bus.id_valid                         = 1'b1;
      bus.id_src_valid[slot]               = 1'b1;
      bus.id_src_no[slot*GR_W +: GR_W]     = GR_W'(r);
      bus.id_src_early[slot]               = early;
   endtask

   task automatic commit(input int rd);
      bus.wb_fire  = 1'b1;
      bus.wb_wen   = 1'b1;
      bus.wb_rd_no = GR_W'(rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle();
      @(posedge aclk);
      #1;
      expect_sig(S_STALL, 0);   expect_sig(S_BUBBLE, 0);
      expect_sig(S_FFLUSH, 0);  expect_sig(S_WBFLUSH, 0);
      expect_sig(S_DISCARD, 0); expect_sig(S_READY, 1);
      expect_sig(S_OUTST, 0);   expect_sig(S_BUSY, 0);
      @(negedge aclk);
      #1;
      reset = 1'b0;

      // ALU producer: late read forwarded, early read stalls until commit
      tick(); issue(5, WK_ALU); expect_sig(S_STALL, 0);
      tick(); rd_src(0, 5, 0); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 1);
      tick(); rd_src(0, 5, 1); expect_sig(S_STALL, 1); expect_sig(S_BUBBLE, 1);
      tick(); rd_src(0, 5, 1); commit(5); expect_sig(S_STALL, 1);
      tick(); rd_src(0, 5, 1); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 0);

      // Load-use on rk
      tick(); issue(7, WK_LOAD); expect_sig(S_STALL, 0);
      for (int k = 0; k < 2; k++) begin
         tick(); rd_src(1, 7, 0); expect_sig(S_STALL, 1); expect_sig(S_BUBBLE, 1);
      end
      tick(); rd_src(1, 7, 0); commit(7); expect_sig(S_STALL, 1); expect_sig(S_BUBBLE, 1);
      tick(); rd_src(1, 7, 0); expect_sig(S_STALL, 0); expect_sig(S_BUBBLE, 0); expect_sig(S_BUSY, 0);

      // Two writers of r3: youngest is ALU
      tick(); issue(3, WK_LOAD);
      tick(); issue(3, WK_ALU);
      tick(); rd_src(2, 3, 0); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 1);
      tick(); rd_src(2, 3, 0); commit(3); expect_sig(S_STALL, 0);
      tick(); rd_src(2, 3, 0); commit(3); expect_sig(S_BUSY, 1);
      tick(); rd_src(2, 3, 1); expect_sig(S_BUSY, 0); expect_sig(S_STALL, 0);

      // r0 never tracked; same-cycle issue+commit of r9 keeps cnt
      tick(); issue(0, WK_LOAD);
      tick(); rd_src(0, 0, 1); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 0);
      tick(); issue(9, WK_LOAD);
      tick(); issue(9, WK_ALU); commit(9); rd_src(0, 9, 1); expect_sig(S_STALL, 1);
      tick(); rd_src(0, 9, 0); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 1);
      tick(); rd_src(0, 9, 1); expect_sig(S_STALL, 1);
      tick(); commit(9); expect_sig(S_BUSY, 1);
      tick(); expect_sig(S_BUSY, 0);

      // kill_younger with three writers in flight, then wb_kill
      tick(); issue(1, WK_LOAD);
      tick(); issue(2, WK_LOAD);
      tick(); issue(4, WK_CSR); expect_sig(S_BUSY, 1);
      tick(); bus.kill_younger = 1'b1; rd_src(0, 1, 0);
      expect_sig(S_FFLUSH, 1); expect_sig(S_WBFLUSH, 0); expect_sig(S_STALL, 0); expect_sig(S_BUBBLE, 0);
      tick(); rd_src(0, 1, 0); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 0); expect_sig(S_FFLUSH, 0);
      tick(); issue(6, WK_LOAD);
      tick(); bus.wb_kill = 1'b1; expect_sig(S_WBFLUSH, 1); expect_sig(S_FFLUSH, 1);
      tick(); rd_src(1, 6, 1); expect_sig(S_STALL, 0); expect_sig(S_BUSY, 0); expect_sig(S_WBFLUSH, 0);

      // Multi-cancel: 3 outstanding, redirect with the new request in the same cycle
      tick(); bus.fetch_req_fire = 1'b1; expect_sig(S_OUTST, 0); expect_sig(S_READY, 1);
      tick(); bus.fetch_req_fire = 1'b1; expect_sig(S_OUTST, 1);
      tick(); bus.fetch_req_fire = 1'b1; expect_sig(S_OUTST, 2);
      tick(); bus.id_redirect = 1'b1; bus.fetch_req_fire = 1'b1;
      expect_sig(S_OUTST, 3); expect_sig(S_READY, 1); expect_sig(S_DISCARD, 0);
      tick(); expect_sig(S_OUTST, 4); expect_sig(S_READY, 0);
      for (int k = 0; k < 4; k++) begin
         tick(); bus.fetch_data_ok = 1'b1;
         expect_sig(S_DISCARD, (k < 3) ? 1 : 0); expect_sig(S_OUTST, 4 - k);
      end
      tick(); expect_sig(S_OUTST, 0); expect_sig(S_READY, 1);

      // Redirect while ID is stalled must not cancel anything
      tick(); issue(8, WK_LOAD); bus.fetch_req_fire = 1'b1;
      tick(); rd_src(0, 8, 0); bus.id_redirect = 1'b1; expect_sig(S_STALL, 1); expect_sig(S_OUTST, 1);
      tick(); bus.fetch_data_ok = 1'b1; commit(8); expect_sig(S_DISCARD, 0);
      tick(); expect_sig(S_OUTST, 0); expect_sig(S_BUSY, 0);

      tick();
      @(negedge aclk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-stage register-compare hazard unit.
- Tracks in-flight register writers in a per-GR scoreboard and decides ID stall or bubble for any number of source operands.
- Replaces the single fetch-cancel bit with an outstanding-fetch counter and a cancel counter, so redirects can discard several in-flight instruction fetches.
- Sits between the ID stage, WB commit, the fetch request interface and the exception/ertn/refetch/idle flush logic.

Parameters:
- NUM_GR, 32, number of general registers; GR 0 is never tracked.
- GR_W, $clog2(NUM_GR), register index width.
- NUM_SRC, 3, ID source operand ports (rj, rk, rd-as-source).
- PIPE_DEPTH, 4, maximum in-flight writers between ID issue and WB commit; sizes the per-register counters.
- MAX_FETCH, 4, maximum outstanding instruction fetch requests.

Ports:
- aclk  in  1  clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_fire  in  1  ID instruction advances to EX this cycle
- id_src_valid  in  NUM_SRC  source i is read
- id_src_no  in  NUM_SRC*GR_W  source register numbers
- id_src_early  in  NUM_SRC  source i is consumed in ID (branch compare, jirl base)
- id_wen  in  1  ID instruction writes a GR
- id_rd_no  in  GR_W  destination register
- id_wkind  in  2  WrKind of the writer: ALU, LOAD, CSR
- wb_fire  in  1  WB instruction commits this cycle
- wb_wen  in  1  committing instruction writes a GR
- wb_rd_no  in  GR_W  committing destination register
- kill_younger  in  1  exception, ertn, refetch or idle detected at MEM or WB
- wb_kill  in  1  WB instruction itself is squashed
- id_redirect  in  1  ID branch or jump taken this cycle
- fetch_req_fire  in  1  IF request accepted by the bus
- fetch_data_ok  in  1  instruction data returned
- fetch_req_ready  out  1  outstanding < MAX_FETCH
- id_stall  out  1  hold ID (ready_go = 0)
- ex_bubble  out  1  insert a bubble into EX
- front_flush  out  1  flush IF, ID, EX and MEM
- wb_flush  out  1  flush WB
- fetch_discard  out  1  the current fetch_data_ok belongs to a cancelled fetch
- outstanding  out  $clog2(MAX_FETCH+1)  outstanding fetch count
- sb_busy  out  1  any scoreboard counter is non-zero

Behaviour:
Reset:
- All counters and kinds clear (kind = ALU).
- All outputs 0, except fetch_req_ready = 1.

Scoreboard state, per register r in 1..NUM_GR-1:
- cnt[r]: width $clog2(PIPE_DEPTH+1).
- kind[r]: kind of the youngest writer.
- Increment when id_fire & id_wen & id_rd_no == r & !kill_younger. kind[r] <= id_wkind on that increment.
- Decrement when wb_fire & wb_wen & wb_rd_no == r & !wb_kill.
- Increment and decrement of the same r in the same cycle: cnt unchanged, kind updated.
- Underflow and overflow past PIPE_DEPTH are assertion failures; RTL saturates.
- kill_younger or wb_kill: every cnt <= 0 next cycle. All surviving writers are squashed; a committing WB writes the register file that cycle.

Source hazard, per source i. hz[i] is set when all of the following hold:
- id_valid and id_src_valid[i];
- src != 0;
- cnt[src] != 0;
- kind[src] != ALU, or id_src_early[i].

Forwarding covers an ALU producer for late consumers only.

Stall outputs:
- id_stall = OR of hz[i], masked to 0 while kill_younger.
- ex_bubble = id_stall, combinational, same cycle.

Flush outputs, all combinational:
- front_flush = kill_younger | wb_kill.
- wb_flush = wb_kill.

Fetch accounting:
- outstanding += fetch_req_fire, -= fetch_data_ok. Both in one cycle: unchanged.
- fetch_req_ready = outstanding < MAX_FETCH. A request fired while not ready is an assertion.

Cancel:
- Trigger: id_redirect & !id_stall, or front_flush.
- On trigger: cancel <= outstanding - (fetch_data_ok & !fetch_discard). The cancel load wins over the decrement.
- fetch_discard = fetch_data_ok & cancel != 0, combinational.
- Otherwise cancel decrements on each discarded data_ok.
- A request fired in the trigger cycle is the redirected fetch and is not counted.
- Reset during operation clears everything asynchronously; no residual discards.

Decomposition:
- cpuDefine holds:
  - typedef enum logic [1:0] WrKind {WK_ALU, WK_LOAD, WK_CSR};
  - the Gr type;
  - localparams PIPE_DEPTH and MAX_FETCH defaults.
- One sub-module, fetch_cancel_ctr: outstanding and cancel counters, fetch_req_ready, fetch_discard.
- The scoreboard array and the source compare stay in the top.

Test Plan:
- ALU forward: issue ALU writer r5, next cycle ID reads r5 late -> id_stall = 0. The same read with early = 1 -> id_stall = 1 until WB commits r5, then 0 the following cycle.
- Load-use: issue LOAD writer r7; next instruction reads r7 as rk -> id_stall = 1 and ex_bubble = 1 every cycle until r7 commits.
- Multiple writers: issue LOAD r3 then ALU r3; late reader of r3 -> no stall (cnt = 2, kind = ALU). After both commit, cnt[3] = 0 and sb_busy = 0.
- Reg 0 and same-cycle events: writes to r0 never stall. Issue and commit of r9 in one cycle leaves cnt[9] unchanged.
- Flush: three writers in flight, then kill_younger -> front_flush = 1 and all cnt = 0 next cycle. A held ID instruction does not stall the cycle after.
- Multi-cancel: 3 fetches outstanding, id_redirect -> the next 3 fetch_data_ok assert fetch_discard and the 4th does not. With 4 outstanding, fetch_req_ready = 0.
